// File: rtl/apb_mem_slave_ws_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mem_slave_ws_if
//  Description : APB4 bus bundle between a master and apb_mem_slave_ws.
//                master modport drives select/enable/address/write fields,
//                slave modport drives prdata/pready/pslverr.
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_mem_slave_ws_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_mem_slave_ws.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mem_slave_ws
//  Description : Parametrised APB4 memory slave with byte strobes,
//                programmable wait states and an error response for
//                out-of-range or misaligned addresses.
//  Ports       : pclk    - clock, rising edge
//                preset  - synchronous active-high reset
//                bus     - APB slave modport (psel/penable/pwrite/paddr/
//                          pwdata/pstrb in; prdata/pready/pslverr out)
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_mem_slave_ws #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  wire logic           pclk,
    input  wire logic           preset,
    apb_mem_slave_ws_if.slave   bus
);
    localparam int         c_strb_w    = DATA_WIDTH / 8;
    localparam int         c_byte_lsb  = $clog2(c_strb_w);
    localparam int         c_idx_w     = ADDR_WIDTH - c_byte_lsb;
    localparam int         c_mem_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_wait_load = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic                   r_write;
    logic [c_mem_aw-1:0]    r_index;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [c_strb_w-1:0]    r_strb;
    logic                   r_err;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [3:0]             r_count;
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

    logic                   w_setup;
    logic [c_idx_w-1:0]     w_index;
    logic [c_mem_aw-1:0]    w_mem_idx;
    logic                   w_out_of_range;
    logic                   w_misalign;
    logic                   w_err;
    logic                   w_done;

    assign w_setup        = bus.psel && !bus.penable;
    assign w_index        = bus.paddr[ADDR_WIDTH-1:c_byte_lsb];
    assign w_mem_idx      = c_mem_aw'(w_index);
    // Full-width compare: no wrap-around of indices beyond DEPTH.
    assign w_out_of_range = (32'(w_index) >= 32'(DEPTH));
    assign w_err          = w_out_of_range || w_misalign;

    // Byte-wide buses have no sub-word address bits to check.
    generate
        if (c_byte_lsb > 0) begin : g_align_chk
            assign w_misalign = |bus.paddr[c_byte_lsb-1:0];
        end else begin : g_no_align_chk
            assign w_misalign = 1'b0;
        end
    endgenerate

    // Completion cycle: in ACCESS with the wait counter exhausted.
    assign w_done = (r_state == S_ACCESS) && (r_count == 4'd0);

    assign bus.pready  = !((r_state == S_ACCESS) && (r_count != 4'd0));
    assign bus.prdata  = (w_done && !r_write) ? r_rdata : '0;
    assign bus.pslverr = w_done ? r_err : 1'b0;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!bus.psel || (r_count == 4'd0)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_write <= 1'b0;
            r_index <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_WIDTH'(i);
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_write <= bus.pwrite;
                        r_index <= w_mem_idx;
                        r_wdata <= bus.pwdata;
                        r_strb  <= bus.pstrb;
                        r_err   <= w_err;
                        r_count <= c_wait_load;
                        // Captured at setup so a write completing on the
                        // previous edge is already visible here.
                        r_rdata <= (!bus.pwrite && !w_err) ? r_mem[w_mem_idx] : '0;
                    end
                end
                S_ACCESS: begin
                    if (!bus.psel) begin
                        r_count <= '0;
                    end else if (r_count != 4'd0) begin
                        if (bus.penable) begin
                            r_count <= r_count - 4'd1;
                        end
                    end else if (r_write && !r_err) begin
                        for (int b = 0; b < c_strb_w; b++) begin
                            if (r_strb[b]) begin
                                r_mem[r_index][8*b +: 8] <= r_wdata[8*b +: 8];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave_ws.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_mem_slave_ws
//  Description : Directed testbench for apb_mem_slave_ws. Three instances
//                (WAIT_STATES = 0, 2, 3) share the bus inputs; sel picks
//                which one receives psel and whose outputs are observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_mem_slave_ws;
    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    int          sel;
    logic [31:0] prdata;
    logic        pready, pslverr;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 pclk = ~pclk;

    apb_mem_slave_ws_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus0 ();
    apb_mem_slave_ws_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus2 ();
    apb_mem_slave_ws_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus3 ();

    assign bus0.psel = psel && (sel == 0);
    assign bus2.psel = psel && (sel == 2);
    assign bus3.psel = psel && (sel == 3);
    assign bus0.penable = penable; assign bus2.penable = penable; assign bus3.penable = penable;
    assign bus0.pwrite  = pwrite;  assign bus2.pwrite  = pwrite;  assign bus3.pwrite  = pwrite;
    assign bus0.paddr   = paddr;   assign bus2.paddr   = paddr;   assign bus3.paddr   = paddr;
    assign bus0.pwdata  = pwdata;  assign bus2.pwdata  = pwdata;  assign bus3.pwdata  = pwdata;
    assign bus0.pstrb   = pstrb;   assign bus2.pstrb   = pstrb;   assign bus3.pstrb   = pstrb;

    apb_mem_slave_ws #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0))
        u_dut0 (.pclk(pclk), .preset(preset), .bus(bus0));
    apb_mem_slave_ws #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(2))
        u_dut2 (.pclk(pclk), .preset(preset), .bus(bus2));
    apb_mem_slave_ws #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3))
        u_dut3 (.pclk(pclk), .preset(preset), .bus(bus3));

    always_comb begin
        prdata = bus0.prdata; pready = bus0.pready; pslverr = bus0.pslverr;
        case (sel)
            2: begin prdata = bus2.prdata; pready = bus2.pready; pslverr = bus2.pslverr; end
            3: begin prdata = bus3.prdata; pready = bus3.pready; pslverr = bus3.pslverr; end
            default: ;
        endcase
    end

    // One APB transfer; returns at the completion cycle (pready=1 sampled)
    // so a following call issues its setup immediately after.
    task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd,
                        output logic er, output int waits);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge pclk); #1;
        penable = 1'b1;
        // Disturb fields that the slave must have latched at setup.
        paddr = a ^ 12'h004; pwdata = ~d; pstrb = ~s;
        waits = 0;
        while (pready !== 1'b1 && waits < 40) begin
            waits++;
            @(posedge pclk); #1;
        end
        if (pready !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL xfer_timeout: pready=%b required 1", pready);
        end
        rd = prdata;
        er = pslverr;
    endtask

    task automatic bus_idle();
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int w;
        sel = 0;
        n_tests++; if (pready !== 1'b1) begin n_fail++; $display("FAIL reset_pready: got %b required 1", pready); end
        n_tests++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h required 0", prdata); end
        n_tests++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b required 0", pslverr); end
        sel = 2; #1;
        n_tests++; if (pready !== 1'b1) begin n_fail++; $display("FAIL reset_pready_ws2: got %b required 1", pready); end
        sel = 0;
        xfer(1'b0, 12'h010, 32'h0, 4'h0, rd, er, w);
        n_tests++; if (rd !== 32'h4 || er !== 1'b0 || w != 0) begin
            n_fail++; $display("FAIL read_0x010: got d=%h e=%b w=%0d required d=00000004 e=0 w=0", rd, er, w);
        end
        bus_idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic er; int w;
        sel = 2;
        xfer(1'b1, 12'h020, 32'hDEADBEEF, 4'hF, rd, er, w);
        n_tests++; if (w != 2 || er !== 1'b0) begin
            n_fail++; $display("FAIL ws2_write: got w=%0d e=%b required w=2 e=0", w, er);
        end
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ws2_write_prdata: got %h required 0", rd); end
        xfer(1'b0, 12'h020, 32'h0, 4'h0, rd, er, w);
        n_tests++; if (rd !== 32'hDEADBEEF || w != 2) begin
            n_fail++; $display("FAIL ws2_read: got d=%h w=%0d required d=deadbeef w=2", rd, w);
        end
        bus_idle();
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic er; int w;
        sel = 0;
        xfer(1'b1, 12'h020, 32'hAABBCCDD, 4'b0101, rd, er, w);
        xfer(1'b0, 12'h020, 32'h0, 4'h0, rd, er, w);
        n_tests++; if (rd !== 32'h00BB00DD) begin n_fail++; $display("FAIL partial_strobe: got %h required 00bb00dd", rd); end
        xfer(1'b1, 12'h024, 32'hFFFFFFFF, 4'b0000, rd, er, w);
        n_tests++; if (er !== 1'b0 || w != 0) begin n_fail++; $display("FAIL zero_strobe_resp: got e=%b w=%0d required e=0 w=0", er, w); end
        xfer(1'b0, 12'h024, 32'h0, 4'h0, rd, er, w);
        n_tests++; if (rd !== 32'h00000009) begin n_fail++; $display("FAIL zero_strobe_mem: got %h required 00000009", rd); end
        bus_idle();
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int w;
        sel = 0;
        xfer(1'b0, 12'h400, 32'h0, 4'h0, rd, er, w);
        n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL oor_read: got e=%b d=%h required e=1 d=0", er, rd); end
        xfer(1'b1, 12'h402, 32'h12345678, 4'hF, rd, er, w);
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL misaligned_write: got e=%b required 1", er); end
        xfer(1'b0, 12'h000, 32'h0, 4'h0, rd, er, w);
        n_tests++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL word0_intact: got d=%h e=%b required d=0 e=0", rd, er); end
        xfer(1'b0, 12'h3FC, 32'h0, 4'h0, rd, er, w);
        n_tests++; if (rd !== 32'h000000FF || er !== 1'b0) begin n_fail++; $display("FAIL last_word_read: got d=%h e=%b required d=000000ff e=0", rd, er); end
        xfer(1'b0, 12'h00E, 32'h0, 4'h0, rd, er, w);
        n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL misaligned_read: got e=%b d=%h required e=1 d=0", er, rd); end
        bus_idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int w;
        sel = 3;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        n_tests++; if (pready !== 1'b0) begin n_fail++; $display("FAIL abort_wait_pready: got %b required 0", pready); end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        n_tests++; if (pready !== 1'b1) begin n_fail++; $display("FAIL abort_idle_pready: got %b required 1", pready); end
        xfer(1'b0, 12'h004, 32'h0, 4'h0, rd, er, w);
        n_tests++; if (rd !== 32'h1 || w != 3) begin n_fail++; $display("FAIL abort_no_write: got d=%h w=%0d required d=00000001 w=3", rd, w); end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int w;
        sel = 3;
        xfer(1'b1, 12'h008, 32'h55555555, 4'hF, rd, er, w);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        n_tests++; if (pready !== 1'b1 || prdata !== 32'h0 || pslverr !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got r=%b d=%h e=%b required r=1 d=0 e=0", pready, prdata, pslverr);
        end
        xfer(1'b0, 12'h008, 32'h0, 4'h0, rd, er, w);
        n_tests++; if (rd !== 32'h2) begin n_fail++; $display("FAIL reset_mid_reinit8: got %h required 00000002", rd); end
        xfer(1'b0, 12'h00C, 32'h0, 4'h0, rd, er, w);
        n_tests++; if (rd !== 32'h3) begin n_fail++; $display("FAIL reset_mid_aborted_write: got %h required 00000003", rd); end
        bus_idle();
        sel = 2;
        xfer(1'b0, 12'h020, 32'h0, 4'h0, rd, er, w);
        n_tests++; if (rd !== 32'h8) begin n_fail++; $display("FAIL reset_mid_reinit_ws2: got %h required 00000008", rd); end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, d; logic er; int w, ws;
        for (int k = 0; k < 2; k++) begin
            sel = (k == 0) ? 0 : 3;
            ws  = (k == 0) ? 0 : 3;
            for (int i = 0; i < 16; i++) begin
                d = $urandom;
                xfer(1'b1, 12'(i * 4), d, 4'hF, rd, er, w);
                n_tests++; if (er !== 1'b0 || w != ws) begin
                    n_fail++; $display("FAIL b2b_write[%0d/%0d]: got e=%b w=%0d required e=0 w=%0d", ws, i, er, w, ws);
                end
                xfer(1'b0, 12'(i * 4), 32'h0, 4'h0, rd, er, w);
                n_tests++; if (rd !== d || er !== 1'b0 || w != ws) begin
                    n_fail++; $display("FAIL b2b_read[%0d/%0d]: got d=%h w=%0d required d=%h w=%0d", ws, i, rd, w, d, ws);
                end
            end
            bus_idle();
        end
    endtask

    initial begin
        preset = 1'b1; sel = 0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        test_reset();
        test_wait_states();
        test_strobes();
        test_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
